// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period of an asynchronous PWM input in clk cycles
// and flags an input that has stopped toggling (stuck high or stuck low).
module pwm_capture #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_i,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic             meas_valid,
   output logic             stuck_hi,
   output logic             stuck_lo
);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

   logic             s1_r, s2_r, s2_d_r;
   logic             rise_s, fall_s, timeout_s;
   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [CNT_W-1:0] hi_tmp_r, hi_tmp_nxt_s;
   logic [CNT_W-1:0] idle_cnt_r, idle_nxt_s;
   logic [CNT_W-1:0] high_nxt_s, period_nxt_s;
   logic             valid_nxt_s, stuck_hi_nxt_s, stuck_lo_nxt_s;

   // Two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r   <= 1'b0;
         s2_r   <= 1'b0;
         s2_d_r <= 1'b0;
      end else begin
         s1_r   <= pwm_i;
         s2_r   <= s1_r;
         s2_d_r <= s2_r;
      end
   end

   // Edge detection and idle counter; the timeout fires only on the step to saturation
   always_comb begin
      rise_s     = s2_r & ~s2_d_r;
      fall_s     = ~s2_r & s2_d_r;
      timeout_s  = 1'b0;
      idle_nxt_s = idle_cnt_r;
      if (rise_s | fall_s) begin
         idle_nxt_s = CNT_ZERO;
      end else if (idle_cnt_r == IDLE_MAX) begin
         idle_nxt_s = idle_cnt_r;
      end else begin
         idle_nxt_s = idle_cnt_r + CNT_ONE;
         timeout_s  = (idle_cnt_r == IDLE_LAST);
      end
   end

   // Next-state and measurement update logic
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      hi_tmp_nxt_s   = hi_tmp_r;
      high_nxt_s     = high_cnt;
      period_nxt_s   = period_cnt;
      valid_nxt_s    = 1'b0;
      stuck_hi_nxt_s = stuck_hi;
      stuck_lo_nxt_s = stuck_lo;
      if (timeout_s) begin
         state_nxt_s    = ST_SYNC;
         stuck_hi_nxt_s = s2_r;
         stuck_lo_nxt_s = ~s2_r;
      end else begin
         case (state_r)
            ST_SYNC: begin
               if (rise_s) begin
                  state_nxt_s = ST_HIGH;
                  cnt_nxt_s   = CNT_ONE;
               end else begin
                  cnt_nxt_s   = cnt_r;
               end
            end
            ST_HIGH: begin
               cnt_nxt_s = cnt_r + CNT_ONE;
               if (fall_s) begin
                  state_nxt_s  = ST_LOW;
                  hi_tmp_nxt_s = cnt_r;
               end else begin
                  state_nxt_s  = ST_HIGH;
               end
            end
            ST_LOW: begin
               if (rise_s) begin
                  state_nxt_s    = ST_HIGH;
                  cnt_nxt_s      = CNT_ONE;
                  period_nxt_s   = cnt_r;
                  high_nxt_s     = hi_tmp_r;
                  valid_nxt_s    = 1'b1;
                  stuck_hi_nxt_s = 1'b0;
                  stuck_lo_nxt_s = 1'b0;
               end else begin
                  cnt_nxt_s      = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_nxt_s = ST_SYNC;
               cnt_nxt_s   = CNT_ZERO;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_SYNC;
         cnt_r      <= CNT_ZERO;
         hi_tmp_r   <= CNT_ZERO;
         idle_cnt_r <= CNT_ZERO;
         high_cnt   <= CNT_ZERO;
         period_cnt <= CNT_ZERO;
         meas_valid <= 1'b0;
         stuck_hi   <= 1'b0;
         stuck_lo   <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         hi_tmp_r   <= hi_tmp_nxt_s;
         idle_cnt_r <= idle_nxt_s;
         high_cnt   <= high_nxt_s;
         period_cnt <= period_nxt_s;
         meas_valid <= valid_nxt_s;
         stuck_hi   <= stuck_hi_nxt_s;
         stuck_lo   <= stuck_lo_nxt_s;
      end
   end

endmodule
